// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read, scoreboard and clear signals of the multi-port register file
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rdata;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic [NREG-1:0]     sb_pend;
  logic                clr_req;
  logic                clr_busy;
  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra, sb_set, sb_addr, clr_req,
    input  rdata, sb_pend, clr_busy
  );
  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra, sb_set, sb_addr, clr_req,
    output rdata, sb_pend, clr_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: dual-write multi-read register file with bypass, pending scoreboard and clear sweep
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t              state_q, state_d;
  logic [AW:0]         idx_q, idx_d;
  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     pend_q, pend_d;
  logic                busy, last, wen0, wen1;
  logic [AW-1:0]       ci, ra_k;
  logic [NRD*XLEN-1:0] rdata_c;
  assign busy = state_q == CLEAR;
  assign ci   = idx_q[AW-1:0];
  assign last = idx_q == (AW+1)'(NREG-1);
  assign wen0 = bus.we0 && !busy && !(ZERO_REG != 0 && bus.wa0 == '0);
  assign wen1 = bus.we1 && !busy && !(ZERO_REG != 0 && bus.wa1 == '0);
  always_comb begin
    state_d = busy ? (last ? IDLE : CLEAR) : (bus.clr_req ? CLEAR : IDLE);
    idx_d   = (busy && !last) ? idx_q + (AW+1)'(1) : '0;
  end
  always_comb begin
    regs_d = regs_q;
    if (wen0) regs_d[bus.wa0] = bus.wd0;
    if (wen1) regs_d[bus.wa1] = bus.wd1;
    if (busy) regs_d[ci] = '0;
  end
  always_comb begin
    pend_d = pend_q;
    if (wen0) pend_d[bus.wa0] = 1'b0;
    if (wen1) pend_d[bus.wa1] = 1'b0;
    if (bus.sb_set && !busy) pend_d[bus.sb_addr] = 1'b1;
    if (busy) pend_d[ci] = 1'b0;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end
  always_comb begin
    rdata_c = '0;
    ra_k    = '0;
    for (int k = 0; k < NRD; k++) begin
      ra_k = bus.ra[k*AW +: AW];
      rdata_c[k*XLEN +: XLEN] =
        (ZERO_REG != 0 && ra_k == '0)              ? '0 :
        busy                                       ? '0 :
        (BYPASS != 0 && bus.we1 && bus.wa1 == ra_k) ? bus.wd1 :
        (BYPASS != 0 && bus.we0 && bus.wa0 == ra_k) ? bus.wd0 :
        regs_q[ra_k];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end
  assign bus.rdata    = rdata_c;
  assign bus.sb_pend  = pend_q;
  assign bus.clr_busy = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with directed vectors
module tb_regfile_mp;
  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } chk_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  chk_t sbq[$];
  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();
  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e   = sbq.pop_front();
      act = e.kind == 0 ? bus.rdata[e.port*32 +: 32] :
            e.kind == 1 ? bus.sb_pend : {31'b0, bus.clr_busy};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s @cyc %0d: got %h want %h", e.name, cyc, act, e.exp);
      end
    end
  end
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: wait expired @cyc %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  task automatic push(input int kind, input int port, input logic [31:0] v, input string n);
    chk_t e;
    e.cyc = cyc; e.kind = kind; e.port = port; e.exp = v; e.name = n;
    sbq.push_back(e);
  endtask
  task automatic exp_rd(input int p, input logic [31:0] v, input string n);
    push(0, p, v, n);
  endtask
  task automatic exp_pend(input logic [31:0] v, input string n);
    push(1, 0, v, n);
  endtask
  task automatic exp_busy(input logic v, input string n);
    push(2, 0, {31'b0, v}, n);
  endtask
  task automatic quiet();
    bus.we0 = 0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 0; bus.wa1 = '0; bus.wd1 = '0;
    bus.sb_set = 0; bus.sb_addr = '0; bus.clr_req = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    quiet();
  endtask
  task automatic set_ra(input int a0, input int a1);
    bus.ra = {5'(a1), 5'(a0)};
  endtask
  initial begin
    quiet();
    set_ra(5, 5);
    step();
    total++;
    if (bus.clr_busy !== 1'b0 || bus.sb_pend !== '0 || bus.rdata !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b pend=%h rdata=%h", bus.clr_busy, bus.sb_pend, bus.rdata);
    end
    exp_rd(0, 32'h0, "reset_rd");
    exp_pend(32'h0, "reset_pend");
    exp_busy(1'b0, "reset_busy");
    step();
    rst_n = 1'b1;
    step();
    bus.we0 = 1; bus.wa0 = 5; bus.wd0 = 32'hDEADBEEF; set_ra(5, 6);
    exp_rd(0, 32'hDEADBEEF, "bypass_w0");
    exp_rd(1, 32'h0, "bypass_nomatch");
    step();
    set_ra(5, 5);
    exp_rd(0, 32'hDEADBEEF, "stored5_p0");
    exp_rd(1, 32'hDEADBEEF, "stored5_p1");
    step();
    bus.we0 = 1; bus.wa0 = 7; bus.wd0 = 32'h11;
    bus.we1 = 1; bus.wa1 = 7; bus.wd1 = 32'h22; set_ra(7, 5);
    exp_rd(0, 32'h22, "bypass_w1_prio");
    step();
    set_ra(7, 7);
    exp_rd(0, 32'h22, "dual_write_p0");
    exp_rd(1, 32'h22, "dual_write_p1");
    step();
    bus.we0 = 1; bus.wa0 = 0; bus.wd0 = 32'hFFFFFFFF;
    bus.we1 = 1; bus.wa1 = 0; bus.wd1 = 32'hFFFFFFFF;
    bus.sb_set = 1; bus.sb_addr = 0; set_ra(0, 0);
    exp_rd(0, 32'h0, "x0_bypass_p0");
    exp_rd(1, 32'h0, "x0_bypass_p1");
    step();
    exp_rd(0, 32'h0, "x0_p0");
    exp_rd(1, 32'h0, "x0_p1");
    exp_pend(32'h0, "x0_pend");
    step();
    bus.sb_set = 1; bus.sb_addr = 3;
    exp_pend(32'h0, "pend_before_set");
    step();
    bus.sb_set = 1; bus.sb_addr = 3;
    bus.we1 = 1; bus.wa1 = 3; bus.wd1 = 32'h33;
    exp_pend(32'h8, "pend_set3");
    step();
    bus.we0 = 1; bus.wa0 = 3; bus.wd0 = 32'h44;
    exp_pend(32'h8, "pend_set_wins");
    step();
    set_ra(3, 3);
    exp_pend(32'h0, "pend_cleared");
    exp_rd(0, 32'h44, "reg3");
    for (int i = 1; i < 32; i++) begin
      step();
      bus.we0 = 1; bus.wa0 = 5'(i); bus.wd0 = 32'(i);
    end
    step();
    set_ra(31, 1);
    exp_rd(0, 32'd31, "fill31");
    exp_rd(1, 32'd1, "fill1");
    step();
    set_ra(9, 17);
    bus.clr_req = 1;
    exp_rd(0, 32'd9, "fill9");
    exp_rd(1, 32'd17, "fill17");
    exp_busy(1'b0, "busy_pre");
    for (int c = 0; c < 32; c++) begin
      step();
      if (c == 10) bus.clr_req = 1;
      if (c == 20) begin bus.we0 = 1; bus.wa0 = 9; bus.wd0 = 32'h55; end
      if (c == 3) begin bus.sb_set = 1; bus.sb_addr = 6; end
      exp_busy(1'b1, $sformatf("busy_c%0d", c));
      if (c == 20) exp_rd(0, 32'h0, "read_during_clear");
    end
    step();
    exp_busy(1'b0, "busy_done");
    exp_pend(32'h0, "pend_after_clear");
    for (int i = 0; i < 32; i++) begin
      step();
      set_ra(i, 31 - i);
      exp_rd(0, 32'h0, $sformatf("clr_p0_r%0d", i));
      exp_rd(1, 32'h0, $sformatf("clr_p1_r%0d", 31 - i));
    end
    step();
    bus.we0 = 1; bus.wa0 = 4; bus.wd0 = 32'hAB;
    step();
    set_ra(4, 4);
    bus.clr_req = 1;
    exp_rd(0, 32'hAB, "reg4_pre_sweep");
    for (int c = 0; c < 4; c++) begin
      step();
      exp_busy(1'b1, $sformatf("busy2_c%0d", c));
    end
    step();
    rst_n = 1'b0;
    exp_busy(1'b0, "busy_async_reset");
    exp_rd(0, 32'h0, "rd_async_reset");
    step();
    rst_n = 1'b1;
    exp_busy(1'b0, "busy_post_reset");
    step();
    exp_busy(1'b0, "busy_idle");
    exp_rd(0, 32'h0, "reg4_post_reset");
    exp_pend(32'h0, "pend_post_reset");
    step();
    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL undrained: %0d checks never compared", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, the next generation of the core's single-write register file. Sits in the ID/WB boundary of the RV32I 5-stage pipeline.
- Adds configurable width, depth and read-port count, plus a second write port.
- Adds an optional hardwired-zero x0 and optional write-to-read bypass.
- Adds a per-register pending scoreboard for hazard detection and a multi-cycle clear engine used after flush/debug reset.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 2. AW = log2(NREG).
- NRD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, and is never pending.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we0  in  1  write enable, port 0 (WB of the ALU/load path).
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (long-latency/MDU writeback).
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- ra  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rdata  out  NRD*XLEN  packed read data; port k occupies bits [k*XLEN +: XLEN].
- sb_set  in  1  mark register sb_addr pending (producer issued).
- sb_addr  in  AW  scoreboard set address.
- sb_pend  out  NREG  pending bit per register.
- clr_req  in  1  start the clear sweep (single-cycle pulse).
- clr_busy  out  1  clear sweep in progress; the pipeline stalls while high.

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - rst_n is asynchronous and active-low.
  - While rst_n = 0: all registers = 0, sb_pend = 0, clr_busy = 0, FSM = IDLE, sweep index = 0.
  - rdata is combinational, so it reads 0 during reset.
- Write:
  - A register updates at the rising edge when its port's enable is high.
  - If we0 and we1 are both high with wa0 == wa1, port 1's data is written.
  - If ZERO_REG = 1, writes to address 0 are discarded.
- Read:
  - Purely combinational, zero latency.
  - Priority for each port k: (a) ZERO_REG = 1 and address 0 → 0; (b) clr_busy = 1 → 0; (c) BYPASS = 1 and we1 with wa1 match → wd1; (d) BYPASS = 1 and we0 with wa0 match → wd0; (e) stored value.
  - BYPASS = 0: reads return the pre-edge stored value.
- Scoreboard:
  - sb_set sets sb_pend[sb_addr] at the next edge.
  - Any accepted write (we0 or we1, not discarded) clears sb_pend[wa] at the next edge.
  - sb_set and a write to the same address in the same cycle: set wins (a new producer has been issued).
  - ZERO_REG = 1: sb_pend[0] is forced to 0.
  - sb_set during CLEAR is ignored.
- Clear FSM:
  - IDLE → CLEAR on clr_req. clr_busy rises at the next edge.
  - In CLEAR, one register per cycle is zeroed and its pend bit cleared, at index 0, 1, …, NREG-1.
  - On the edge that clears index NREG-1: → IDLE, clr_busy = 0, index = 0.
  - Total clr_busy high time = NREG cycles.
  - we0 and we1 are dropped while clr_busy = 1.
  - clr_req while in CLEAR is ignored; the sweep is not restarted.
  - clr_req in the same cycle as a write in IDLE: the write is performed, then the sweep starts (the written register is later zeroed).
- Reset mid-sweep: immediately returns to IDLE with everything zero.
- Address wrap: the sweep index is AW+1 bits wide internally, so there is no wrap-around aliasing.

Test Plan:
- Reset, then we0 = 1, wa0 = 5, wd0 = 0xDEADBEEF with ra port0 = 5 in the same cycle → BYPASS = 1: rdata0 = 0xDEADBEEF that cycle; BYPASS = 0: 0 that cycle and 0xDEADBEEF the next cycle.
- we0 = 1, wa0 = 7, wd0 = 0x11 and we1 = 1, wa1 = 7, wd1 = 0x22 → next cycle reg7 reads 0x22.
- ZERO_REG = 1: write 0xFFFFFFFF to x0 → x0 reads 0 on all NRD ports. Also sb_set with sb_addr = 0 → sb_pend[0] stays 0.
- sb_set with sb_addr = 3 → sb_pend = 0x8. Then sb_set to 3 together with we1 to 3 → sb_pend[3] stays 1. Then we0 to 3 alone → sb_pend = 0.
- Fill regs 1..31 with their own index, then pulse clr_req → clr_busy high for exactly 32 cycles.
  - During the sweep, a write of 0x55 to reg 9 is dropped.
  - After the sweep, all registers read 0.
  - A second clr_req at sweep cycle 10 has no effect.
- Mid-sweep (cycle 4), assert rst_n = 0 → clr_busy = 0 asynchronously. After release, the FSM is in IDLE and all reads return 0.
